dff_edge_rebuild: RTL and testbench

- Receive-side counterpart of the registered edge-detector FSM.
- Consumes one-cycle rise (r) and fall (f) event pulses and regenerates the original level signal.
- Measures each high period in clock cycles and reports it as a registered length word.
- Flags protocol violations: fall without a prior rise, or rise while already high.

---
 rtl/dff_edge_rebuild.sv | 161 ++++++++++++++++
 tb/tb_dff_edge_rebuild.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_edge_rebuild.sv
`default_nettype none
// ============================================================================
// Module   : dff_edge_rebuild
// Purpose  : Rebuilds a level signal from one-cycle rise (r) and fall (f)
//            event pulses. Measures each high period in clock cycles and
//            flags protocol violations: a fall with no prior rise, or a
//            rise while already high.
// Options  : DFF_EDGE_REBUILD_TIMEOUT_EN enables the forced abort of a
//            high period after TIMEOUT cycles (pulses tmo and err).
// Revision : 1.0 - initial release
// ============================================================================
module dff_edge_rebuild #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r,
    input  logic             f,
    output logic             lvl,
    output logic [CNT_W-1:0] len,
    output logic             len_vld,
    output logic             err,
    output logic             tmo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reject parameter sets the counter cannot represent.
    if (CNT_W < 2 || CNT_W > 16 || TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_param_check
        $error("dff_edge_rebuild: illegal CNT_W/TIMEOUT combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             len_vld_q, len_vld_d;
    logic             err_q, err_d;

`ifdef DFF_EDGE_REBUILD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
    logic             tmo_q, tmo_d;
`endif

    // Saturating increment: a very long high period reports the max length, never a wrapped one.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state and output decode; event pulses default low every cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lvl_d     = lvl_q;
        len_d     = len_q;
        len_vld_d = 1'b0;
        err_d     = 1'b0;
`ifdef DFF_EDGE_REBUILD_TIMEOUT_EN
        tmo_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (f) begin
                    // A fall with no run to end, or an ambiguous r+f, is rejected.
                    err_d = 1'b1;
                end else if (r) begin
                    state_d = ST_HIGH;
                    lvl_d   = 1'b1;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_HIGH: begin
                cnt_d = cnt_inc;
                if (f) begin
                    // A simultaneous r is flagged, but the fall still closes the run.
                    err_d     = r;
                    state_d   = ST_DONE;
                    lvl_d     = 1'b0;
                    len_d     = cnt_inc;
                    len_vld_d = 1'b1;
                end
`ifdef DFF_EDGE_REBUILD_TIMEOUT_EN
                else if (cnt_q == TMO_VAL) begin
                    // Abandon the run without publishing a length.
                    state_d = ST_IDLE;
                    lvl_d   = 1'b0;
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                end
`endif
                else if (r) begin
                    err_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (f) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (r) begin
                    // Back-to-back run: the level goes low for exactly one cycle.
                    state_d = ST_HIGH;
                    lvl_d   = 1'b1;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lvl_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset aborts any run silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lvl_q     <= 1'b0;
            len_q     <= '0;
            len_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            len_q     <= len_d;
            len_vld_q <= len_vld_d;
            err_q     <= err_d;
        end
    end

`ifdef DFF_EDGE_REBUILD_TIMEOUT_EN
    // Timeout pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    assign lvl     = lvl_q;
    assign len     = len_q;
    assign len_vld = len_vld_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_edge_rebuild.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_edge_rebuild
// Purpose  : Self-checking bench for dff_edge_rebuild. Three instances share
//            one r/f stream: A (CNT_W=8, TIMEOUT=200), B (CNT_W=4,
//            TIMEOUT=12), C (CNT_W=8, TIMEOUT=10). Expected outputs per
//            cycle are queued when stimulus is driven and compared after the
//            following clock edge, plus directed checks of key values.
// Options  : honours DFF_EDGE_REBUILD_TIMEOUT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_edge_rebuild;

`ifdef DFF_EDGE_REBUILD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r;
    logic       f;
    logic       lvl_a, lvl_b, lvl_c;
    logic [7:0] len_a, len_c;
    logic [3:0] len_b;
    logic       vld_a, vld_b, vld_c;
    logic       err_a, err_b, err_c;
    logic       tmo_a, tmo_b, tmo_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_edge_rebuild #(.CNT_W(8), .TIMEOUT(200)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .r(r), .f(f),
        .lvl(lvl_a), .len(len_a), .len_vld(vld_a), .err(err_a), .tmo(tmo_a)
    );
    dff_edge_rebuild #(.CNT_W(4), .TIMEOUT(12)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .r(r), .f(f),
        .lvl(lvl_b), .len(len_b), .len_vld(vld_b), .err(err_b), .tmo(tmo_b)
    );
    dff_edge_rebuild #(.CNT_W(8), .TIMEOUT(10)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .r(r), .f(f),
        .lvl(lvl_c), .len(len_c), .len_vld(vld_c), .err(err_c), .tmo(tmo_c)
    );

    // Observed outputs indexed by instance.
    logic        lvl_w [3];
    logic [31:0] len_w [3];
    logic        vld_w [3];
    logic        err_w [3];
    logic        tmo_w [3];
    assign lvl_w[0] = lvl_a;  assign lvl_w[1] = lvl_b;  assign lvl_w[2] = lvl_c;
    assign len_w[0] = {24'd0, len_a};
    assign len_w[1] = {28'd0, len_b};
    assign len_w[2] = {24'd0, len_c};
    assign vld_w[0] = vld_a;  assign vld_w[1] = vld_b;  assign vld_w[2] = vld_c;
    assign err_w[0] = err_a;  assign err_w[1] = err_b;  assign err_w[2] = err_c;
    assign tmo_w[0] = tmo_a;  assign tmo_w[1] = tmo_b;  assign tmo_w[2] = tmo_c;

    // Behavioural reference: st 0=idle, 1=high, 2=one-cycle recovery.
    typedef struct {
        int st;
        int run;
        bit lvl;
        int len;
        bit vld;
        bit err;
        bit tmo;
    } mdl_t;

    typedef struct {
        int   idx;
        mdl_t m;
    } sb_t;

    mdl_t mdl  [3];
    int   maxv [3];
    int   tlim [3];
    sb_t  sb   [$];

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.st = 0; n.run = 0; n.lvl = 0; n.len = 0;
        n.vld = 0; n.err = 0; n.tmo = 0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit rr, bit ff, int mx, int tl);
        mdl_t n;
        int   nxt;
        n = m;
        n.vld = 0; n.err = 0; n.tmo = 0;
        nxt = (m.run + 1 > mx) ? mx : m.run + 1;
        if (m.st == 0) begin
            if (ff) n.err = 1;
            else if (rr) begin n.st = 1; n.lvl = 1; n.run = 1; end
        end else if (m.st == 1) begin
            n.run = nxt;
            if (ff) begin
                n.err = rr; n.st = 2; n.lvl = 0; n.len = nxt; n.vld = 1;
            end else if (TMO_EN && m.run == tl) begin
                n.st = 0; n.lvl = 0; n.tmo = 1; n.err = 1;
            end else if (rr) begin
                n.err = 1;
            end
        end else begin
            if (ff) begin n.err = 1; n.st = 0; end
            else if (rr) begin n.st = 1; n.lvl = 1; n.run = 1; end
            else n.st = 0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue expectations, compare after the edge.
    task automatic cycle(input bit rr, input bit ff);
        sb_t e;
        @(negedge clk);
        r = rr;
        f = ff;
        for (int i = 0; i < 3; i++) begin
            e.idx = i;
            e.m   = mdl_step(mdl[i], rr, ff, maxv[i], tlim[i]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("sb%0d_lvl", e.idx), {31'd0, lvl_w[e.idx]}, {31'd0, e.m.lvl});
            chk($sformatf("sb%0d_len", e.idx), len_w[e.idx], e.m.len);
            chk($sformatf("sb%0d_vld", e.idx), {31'd0, vld_w[e.idx]}, {31'd0, e.m.vld});
            chk($sformatf("sb%0d_err", e.idx), {31'd0, err_w[e.idx]}, {31'd0, e.m.err});
            chk($sformatf("sb%0d_tmo", e.idx), {31'd0, tmo_w[e.idx]}, {31'd0, e.m.tmo});
            mdl[e.idx] = e.m;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hi_cnt;
        bit  seen_tmo;
        bit  seen_tmo_err;
        int  len_before;

        maxv = '{255, 15, 255};
        tlim = '{200, 12, 10};
        for (int i = 0; i < 3; i++) mdl[i] = mdl_reset();

        // Power-on reset.
        rst_n = 1'b0;
        r = 1'b0;
        f = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lvl", {31'd0, lvl_a}, 0);
        chk("rst_len", {24'd0, len_a}, 0);
        chk("rst_vld", {31'd0, vld_a}, 0);
        chk("rst_err", {31'd0, err_a}, 0);
        chk("rst_tmo", {31'd0, tmo_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run: r, 5 idle, f -> len 7, lvl high 6 cycles.
        hi_cnt = 0;
        cycle(1'b1, 1'b0);
        if (lvl_a) hi_cnt++;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            if (lvl_a) hi_cnt++;
        end
        chk("t1_hi_cycles", hi_cnt, 6);
        cycle(1'b0, 1'b1);
        chk("t1_len", {24'd0, len_a}, 7);
        chk("t1_vld", {31'd0, vld_a}, 1);
        chk("t1_lvl", {31'd0, lvl_a}, 0);
        chk("t1_err", {31'd0, err_a}, 0);
        cycle(1'b0, 1'b0);
        chk("t1_vld_once", {31'd0, vld_a}, 0);
        idle(2);

        // Fall while idle.
        cycle(1'b0, 1'b1);
        chk("t2_err", {31'd0, err_a}, 1);
        chk("t2_lvl", {31'd0, lvl_a}, 0);
        chk("t2_vld", {31'd0, vld_a}, 0);
        chk("t2_len_kept", {24'd0, len_a}, 7);
        cycle(1'b0, 1'b0);
        chk("t2_err_once", {31'd0, err_a}, 0);

        // Double rise: error once, level held, len 6.
        cycle(1'b1, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0);
        chk("t3_err", {31'd0, err_a}, 1);
        chk("t3_lvl", {31'd0, lvl_a}, 1);
        cycle(1'b0, 1'b0);
        chk("t3_err_once", {31'd0, err_a}, 0);
        chk("t3_lvl_hold", {31'd0, lvl_a}, 1);
        cycle(1'b0, 1'b1);
        chk("t3_len", {24'd0, len_a}, 6);
        chk("t3_vld", {31'd0, vld_a}, 1);
        idle(2);

        // Long run: the 4-bit counter saturates at 15.
        cycle(1'b1, 1'b0);
        idle(30);
        cycle(1'b0, 1'b1);
        chk("t4_len_a", {24'd0, len_a}, 32);
`ifndef DFF_EDGE_REBUILD_TIMEOUT_EN
        chk("t4_len_b_sat", {28'd0, len_b}, 15);
        chk("t4_vld_b", {31'd0, vld_b}, 1);
        chk("t4_err_b", {31'd0, err_b}, 0);
`endif
        idle(2);

        // Back-to-back: fall then rise in the recovery cycle.
        cycle(1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1);
        chk("t5_lvl_low", {31'd0, lvl_a}, 0);
        cycle(1'b1, 1'b0);
        chk("t5_lvl_high", {31'd0, lvl_a}, 1);
        chk("t5_err", {31'd0, err_a}, 0);
        idle(2);
        cycle(1'b0, 1'b1);
        chk("t5_len", {24'd0, len_a}, 4);
        idle(2);

        // Mid-run asynchronous reset.
        cycle(1'b1, 1'b0);
        idle(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_lvl_async", {31'd0, lvl_a}, 0);
        chk("t6_vld", {31'd0, vld_a}, 0);
        chk("t6_len", {24'd0, len_a}, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("t6_err", {31'd0, err_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) mdl[i] = mdl_reset();
        idle(1);

        // Establish a nonzero len, then a run long enough to time out on C.
        cycle(1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1);
        idle(2);
        len_before   = {24'd0, len_c};
        seen_tmo     = 0;
        seen_tmo_err = 0;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b0);
            if (tmo_c) begin
                seen_tmo = 1;
                seen_tmo_err = err_c;
                chk("t7_lvl_on_tmo", {31'd0, lvl_c}, 0);
            end
        end
        chk("t7_tmo_seen", {31'd0, seen_tmo}, {31'd0, TMO_EN});
        chk("t7_tmo_err", {31'd0, seen_tmo_err}, {31'd0, TMO_EN});
        chk("t7_len_kept", {24'd0, len_c}, len_before);
        cycle(1'b0, 1'b1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
